// File: rtl/valu_issue_ctrl_if.sv
// Signal bundle between the two issue requesters, the vector ALU and the
// response consumer. The slave view belongs to valu_issue_ctrl.
interface valu_issue_ctrl_if #(
  parameter int unsigned TAG_W = 6
);
  logic              req0_valid;
  logic              req0_ready;
  logic [31:0]       req0_control;
  logic [15:0]       req0_exec;
  logic [15:0]       req0_vcc;
  logic [TAG_W-1:0]  req0_tag;

  logic              req1_valid;
  logic              req1_ready;
  logic [31:0]       req1_control;
  logic [15:0]       req1_exec;
  logic [15:0]       req1_vcc;
  logic [TAG_W-1:0]  req1_tag;

  logic [31:0]       alu_control;
  logic [15:0]       alu_source_exec_value;
  logic [15:0]       alu_source_vcc_value;
  logic              alu_start;
  logic              valu_done;
  logic [15:0]       alu_sgpr_dest_data;
  logic [15:0]       alu_dest_vcc_value;

  logic              resp_valid;
  logic              resp_ready;
  logic              resp_src;
  logic [TAG_W-1:0]  resp_tag;
  logic [15:0]       resp_sgpr;
  logic [15:0]       resp_vcc;
  logic              resp_timeout;

  logic              busy;

  modport slave (
    input  req0_valid, req0_control, req0_exec, req0_vcc, req0_tag,
    input  req1_valid, req1_control, req1_exec, req1_vcc, req1_tag,
    output req0_ready, req1_ready,
    output alu_control, alu_source_exec_value, alu_source_vcc_value, alu_start,
    input  valu_done, alu_sgpr_dest_data, alu_dest_vcc_value,
    output resp_valid, resp_src, resp_tag, resp_sgpr, resp_vcc, resp_timeout,
    input  resp_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_control, req0_exec, req0_vcc, req0_tag,
    output req1_valid, req1_control, req1_exec, req1_vcc, req1_tag,
    input  req0_ready, req1_ready,
    input  alu_control, alu_source_exec_value, alu_source_vcc_value, alu_start,
    output valu_done, alu_sgpr_dest_data, alu_dest_vcc_value,
    input  resp_valid, resp_src, resp_tag, resp_sgpr, resp_vcc, resp_timeout,
    output resp_ready,
    input  busy
  );
endinterface

// File: rtl/valu_issue_ctrl.sv
// Issue sequencer for the 16-lane vector ALU: round-robin between two
// requesters, one op in flight, back-pressured response with a WAIT timeout.
module valu_issue_ctrl #(
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  valu_issue_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [31:0]       ctrl_q, ctrl_d;
  logic [15:0]       exec_q, exec_d;
  logic [15:0]       svcc_q, svcc_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              src_q, src_d;
  logic [15:0]       rsgpr_q, rsgpr_d;
  logic [15:0]       rvcc_q, rvcc_d;
  logic              rto_q, rto_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              grant_vld, grant_sel;
  logic [31:0]       sel_ctrl;
  logic [15:0]       sel_exec, sel_vcc;
  logic [TAG_W-1:0]  sel_tag;
  logic              to_hit;
  logic              ready0, ready1, start;

  // With both valid the requester not granted last time wins.
  always_comb begin
    grant_vld = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) grant_sel = ~last_q;
    else                                  grant_sel = bus.req1_valid;
    sel_ctrl = grant_sel ? bus.req1_control : bus.req0_control;
    sel_exec = grant_sel ? bus.req1_exec    : bus.req0_exec;
    sel_vcc  = grant_sel ? bus.req1_vcc     : bus.req0_vcc;
    sel_tag  = grant_sel ? bus.req1_tag     : bus.req0_tag;
  end

  assign to_hit = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == 32'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    ctrl_d  = ctrl_q;
    exec_d  = exec_q;
    svcc_d  = svcc_q;
    tag_d   = tag_q;
    src_d   = src_q;
    rsgpr_d = rsgpr_q;
    rvcc_d  = rvcc_q;
    rto_d   = rto_q;
    cnt_d   = cnt_q;
    ready0  = 1'b0;
    ready1  = 1'b0;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rst && grant_vld) begin
          ready0 = ~grant_sel;
          ready1 = grant_sel;
          last_d = grant_sel;
          ctrl_d = sel_ctrl;
          exec_d = sel_exec;
          svcc_d = sel_vcc;
          tag_d  = sel_tag;
          src_d  = grant_sel;
          // A zero control word never completes on the ALU, so answer it here.
          if (sel_ctrl == 32'd0) begin
            rsgpr_d = 16'd0;
            rvcc_d  = sel_vcc;
            rto_d   = 1'b0;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        start   = ~rst;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.valu_done) begin
          rsgpr_d = bus.alu_sgpr_dest_data;
          rvcc_d  = bus.alu_dest_vcc_value;
          rto_d   = 1'b0;
          state_d = RESP;
        end else if (to_hit) begin
          rsgpr_d = 16'd0;
          rvcc_d  = 16'd0;
          rto_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        // ALU inputs stay put until the response is taken so done cannot glitch.
        if (bus.resp_ready) begin
          ctrl_d  = 32'd0;
          exec_d  = 16'd0;
          svcc_d  = 16'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      ctrl_q  <= 32'd0;
      exec_q  <= 16'd0;
      svcc_q  <= 16'd0;
      tag_q   <= '0;
      src_q   <= 1'b0;
      rsgpr_q <= 16'd0;
      rvcc_q  <= 16'd0;
      rto_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      ctrl_q  <= ctrl_d;
      exec_q  <= exec_d;
      svcc_q  <= svcc_d;
      tag_q   <= tag_d;
      src_q   <= src_d;
      rsgpr_q <= rsgpr_d;
      rvcc_q  <= rvcc_d;
      rto_q   <= rto_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req0_ready            = ready0;
  assign bus.req1_ready            = ready1;
  assign bus.alu_control           = ctrl_q;
  assign bus.alu_source_exec_value = exec_q;
  assign bus.alu_source_vcc_value  = svcc_q;
  assign bus.alu_start             = start;
  assign bus.resp_valid            = (state_q == RESP);
  assign bus.resp_src              = src_q;
  assign bus.resp_tag              = tag_q;
  assign bus.resp_sgpr             = rsgpr_q;
  assign bus.resp_vcc              = rvcc_q;
  assign bus.resp_timeout          = rto_q;
  assign bus.busy                  = (state_q != IDLE);

endmodule

// File: doc/valu_issue_ctrl.md
Name: valu_issue_ctrl

Overview:
- Sequences the 16-lane vector ALU (SIMD or SIMF build).
- Round-robin arbitrates between two issue requesters with valid/ready handshakes.
- Latches the winner's control word, exec mask and VCC onto the ALU and pulses start, then waits for the ALU's aggregate done.
- Returns the 16-bit SGPR/VCC results with a tag through a back-pressured response port, and flags hung operations with a timeout.

Parameters:
- TAG_W, 6, width of the requester tag (wavefront id) carried to the response.
- TIMEOUT, 1023, cycles allowed in WAIT before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req0_valid / req1_valid  in  1  requester has an op.
- req0_ready / req1_ready  out  1  op accepted this cycle.
- req0_control / req1_control  in  32  ALU control word.
- req0_exec / req1_exec  in  16  exec mask.
- req0_vcc / req1_vcc  in  16  source VCC.
- req0_tag / req1_tag  in  TAG_W  requester tag.
- alu_control  out  32  to ALU, held stable for the whole op.
- alu_source_exec_value  out  16  to ALU.
- alu_source_vcc_value  out  16  to ALU.
- alu_start  out  1  one-cycle start pulse.
- valu_done  in  1  ALU aggregate done.
- alu_sgpr_dest_data  in  16  ALU SGPR result.
- alu_dest_vcc_value  in  16  ALU VCC result.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_src  out  1  requester index of the result.
- resp_tag  out  TAG_W  tag of the result.
- resp_sgpr  out  16  latched SGPR result.
- resp_vcc  out  16  latched VCC result.
- resp_timeout  out  1  result is an aborted op; data is zero.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE; RR pointer favours req0; all outputs 0 (alu_control 0, alu_start 0, ready 0, resp_* 0, busy 0).
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - ready is asserted combinationally to exactly one valid requester.
  - Winner selection: if only one requester is valid, it wins. If both are valid, the requester not granted last time wins (the pointer holds the last grant; after reset req0 wins).
  - On a handshake: latch control/exec/vcc/tag/src, update the pointer, and go to ISSUE.
  - NOP op (req control == 0, for which the ALU never signals done): latch control 0, skip the ALU, and go straight to RESP with resp_sgpr = 0 and resp_vcc = req vcc.
- ISSUE:
  - alu_start = 1 for exactly this cycle; ALU inputs already hold the latched values.
  - valu_done is ignored in this cycle.
  - Go to WAIT and clear the timeout counter.
- WAIT:
  - Sample valu_done each cycle. When done = 1, capture alu_sgpr_dest_data and alu_dest_vcc_value, then go to RESP.
  - The timeout counter increments each WAIT cycle. On reaching TIMEOUT with done still 0: go to RESP with resp_timeout = 1 and sgpr/vcc = 0.
  - If done and timeout occur in the same cycle, done wins.
  - Minimum latency: accept at cycle N, start at N+1, done earliest at N+2, resp_valid at N+3.
- RESP:
  - resp_valid = 1; resp_* are stable until resp_ready.
  - On resp_valid & resp_ready, go to IDLE; ready stays 0 in that cycle (no same-cycle accept), so back-to-back issue spacing is at least 4 cycles.
- ALU input hold: alu_control/exec/vcc are held from ISSUE through RESP. They return to 0 only on entering IDLE, so done does not glitch while the response waits.
- An exec mask of 0 is legal; the ALU reports done immediately and the result is passed through unchanged.
- Requests: requesters must hold valid and their payload stable until ready; a valid that is dropped without ready is simply not served.
- Reset mid-op: at any state, rst forces IDLE in the next cycle.
  - Any in-flight op is discarded with no response; alu_start is never asserted in the reset cycle.
  - alu_control drops to 0.

Test Plan:
- Single op: req0 control 0x00000011, exec 0xFFFF, vcc 0x00F0, tag 5; ALU done 2 cycles after start with sgpr 0xA5A5, vcc 0x0F0F -> exactly one alu_start pulse; resp_valid with src 0, tag 5, sgpr 0xA5A5, vcc 0x0F0F, timeout 0.
- Contention: req0 and req1 both valid continuously for 4 ops -> grant order 0,1,0,1; never two readies in one cycle; each op waits for the previous response.
- Back-pressure: hold resp_ready = 0 for 10 cycles -> resp_* stable, alu_control unchanged, no new ready; accept at cycle 11 -> IDLE next cycle.
- NOP: req1 control 0, vcc 0x1234 -> no alu_start; resp_valid 1 cycle after accept with sgpr 0, vcc 0x1234.
- Timeout: TIMEOUT = 8, valu_done held 0 -> resp_timeout = 1 after 8 WAIT cycles, data 0. Repeat with done rising on the 8th cycle -> normal result, timeout 0.
- Reset in WAIT: assert rst for 1 cycle during WAIT -> busy = 0, alu_control = 0, no resp_valid; next request is served and its grant follows the reset pointer (req0 if both valid).
